// File: rtl/adc1_spi_pkg.sv
// -----------------------------------------------------------------------------
// adc1_spi_pkg
// Shared definitions for the ADC1 APD-bias SPI reader:
//   - default frame geometry and timing constants
//   - FSM state encoding
//   - clog2 helper used to size counters
// -----------------------------------------------------------------------------
package adc1_spi_pkg;

    localparam int DEF_CLK_DIV    = 4;
    localparam int DEF_FRAME_BITS = 16;
    localparam int DEF_DATA_BITS  = 12;
    localparam int DEF_QUIET_CYC  = 20;
    localparam int DEF_AVG_LOG2   = 3;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CS_SETUP = 3'd1,
        ST_SHIFT    = 3'd2,
        ST_CS_HOLD  = 3'd3,
        ST_QUIET    = 3'd4
    } state_e;

    // Ceiling log2, never smaller than 1 so a counter always has a bit.
    function automatic int clog2(input int value);
        int r;
        r = 1;
        for (int i = 0; i < 31; i++) begin
            if ((32'd1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/adc1_spi_reader_sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Generic two-flop synchronizer for asynchronous inputs (ADC1_SDO, FAN0_PLUS,
// other EMIO inputs).
// Ports:
//   clk_i   system clock
//   rst_ni  asynchronous active-low reset (flops clear to RESET_VAL)
//   d_i     asynchronous input
//   q_o     synchronized output, two clk_i cycles of latency
// -----------------------------------------------------------------------------
module sync_2ff #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // Two-stage capture chain; only sync_q is used downstream.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/adc1_spi_reader.sv
// -----------------------------------------------------------------------------
// adc1_spi_reader
// Read-only SPI master (CPOL=1, CPHA=1) for the ADC1 APD-bias readback ADC.
// Each frame is FRAME_BITS SCK periods; the low DATA_BITS bits are the sample,
// the leading bits must be zero (otherwise frame_err is set, sticky).
// Optional build macro ADC1_AVG_EN: average 2^AVG_LOG2 frames per output.
// Ports:
//   clk, rst_n         system clock, asynchronous active-low reset
//   start              single-shot request (ignored while busy)
//   auto_en            continuous back-to-back frames
//   adc_csn, adc_sck   SPI chip select / clock (registered)
//   adc_sdo            SPI data from ADC (asynchronous, synchronized here)
//   sample_data        last sample (or average)
//   sample_valid       one-cycle strobe when sample_data updates
//   frame_err, err_clr sticky leading-bit error flag and its clear
//   busy               high from CS_SETUP entry until QUIET exit
// -----------------------------------------------------------------------------
module adc1_spi_reader
    import adc1_spi_pkg::*;
#(
    parameter int CLK_DIV    = DEF_CLK_DIV,
    parameter int FRAME_BITS = DEF_FRAME_BITS,
    parameter int DATA_BITS  = DEF_DATA_BITS,
    parameter int QUIET_CYC  = DEF_QUIET_CYC
`ifdef ADC1_AVG_EN
    ,
    parameter int AVG_LOG2   = DEF_AVG_LOG2
`endif
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 auto_en,
    output logic                 adc_csn,
    output logic                 adc_sck,
    input  logic                 adc_sdo,
    output logic [DATA_BITS-1:0] sample_data,
    output logic                 sample_valid,
    output logic                 frame_err,
    input  logic                 err_clr,
    output logic                 busy
);

    localparam int             BIT_W      = clog2(FRAME_BITS);
    localparam logic [7:0]     DIV_LAST   = 8'(CLK_DIV - 1);
    localparam logic [15:0]    QUIET_LAST = 16'(QUIET_CYC - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);

    state_e                 state_q, state_d;
    logic [7:0]             div_q, div_d;
    logic                   phase_q, phase_d;      // 0 = SCK low half, 1 = high half
    logic [BIT_W-1:0]       bit_q, bit_d;
    logic [15:0]            quiet_q, quiet_d;
    logic [FRAME_BITS-1:0]  shift_q, shift_d;
    logic                   csn_q, csn_d;
    logic                   sck_q, sck_d;
    logic                   busy_q, busy_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   err_q, err_d;
    logic                   sdo_sync;

`ifdef ADC1_AVG_EN
    localparam int                ACC_W    = DATA_BITS + AVG_LOG2;
    localparam logic [AVG_LOG2-1:0] AVG_LAST = {AVG_LOG2{1'b1}};

    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [AVG_LOG2-1:0] avg_cnt_q, avg_cnt_d;
    logic                auto_en_q;
    logic                avg_clr_s;
    logic [ACC_W-1:0]    sum_s;

    assign avg_clr_s = auto_en & ~auto_en_q;
    assign sum_s     = acc_q + ACC_W'(shift_q[DATA_BITS-1:0]);
`endif

    sync_2ff #(
        .WIDTH     (1),
        .RESET_VAL (1'b0)
    ) u_sdo_sync (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .d_i    (adc_sdo),
        .q_o    (sdo_sync)
    );

    // Next-state logic for the frame sequencer and the output registers.
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        phase_d = phase_q;
        bit_d   = bit_q;
        quiet_d = quiet_q;
        shift_d = shift_q;
        csn_d   = csn_q;
        sck_d   = sck_q;
        busy_d  = busy_q;
        data_d  = data_q;
        valid_d = 1'b0;
        // A new error below overrides this clear.
        err_d   = err_q & ~err_clr;
`ifdef ADC1_AVG_EN
        acc_d     = acc_q;
        avg_cnt_d = avg_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start || auto_en) begin
                    state_d = ST_CS_SETUP;
                    csn_d   = 1'b0;
                    sck_d   = 1'b1;
                    busy_d  = 1'b1;
                    div_d   = 8'd0;
                end else begin
                    csn_d  = 1'b1;
                    sck_d  = 1'b1;
                    busy_d = 1'b0;
                end
            end
            ST_CS_SETUP: begin
                if (div_q == DIV_LAST) begin
                    state_d = ST_SHIFT;
                    sck_d   = 1'b0;
                    div_d   = 8'd0;
                    phase_d = 1'b0;
                    bit_d   = '0;
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            ST_SHIFT: begin
                if (div_q != DIV_LAST) begin
                    div_d = div_q + 8'd1;
                end else if (!phase_q) begin
                    // End of the low half: the ADC's bit has settled since the
                    // falling edge, so capture it here.
                    shift_d = {shift_q[FRAME_BITS-2:0], sdo_sync};
                    phase_d = 1'b1;
                    sck_d   = 1'b1;
                    div_d   = 8'd0;
                end else if (bit_q != BIT_LAST) begin
                    bit_d   = bit_q + BIT_W'(1);
                    phase_d = 1'b0;
                    sck_d   = 1'b0;
                    div_d   = 8'd0;
                end else begin
                    // Frame complete: deliver the sample on CS_HOLD entry.
                    state_d = ST_CS_HOLD;
                    div_d   = 8'd0;
                    if (|shift_q[FRAME_BITS-1:DATA_BITS]) begin
                        err_d = 1'b1;
                    end else begin
                        err_d = err_q & ~err_clr;
                    end
`ifdef ADC1_AVG_EN
                    if (avg_cnt_q == AVG_LAST) begin
                        data_d    = sum_s[ACC_W-1:AVG_LOG2];
                        valid_d   = 1'b1;
                        acc_d     = '0;
                        avg_cnt_d = '0;
                    end else begin
                        acc_d     = sum_s;
                        avg_cnt_d = avg_cnt_q + AVG_LOG2'(1);
                    end
`else
                    data_d  = shift_q[DATA_BITS-1:0];
                    valid_d = 1'b1;
`endif
                end
            end
            ST_CS_HOLD: begin
                if (div_q == DIV_LAST) begin
                    state_d = ST_QUIET;
                    csn_d   = 1'b1;
                    quiet_d = 16'd0;
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            ST_QUIET: begin
                if (quiet_q == QUIET_LAST) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    quiet_d = quiet_q + 16'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                csn_d   = 1'b1;
                sck_d   = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset drops any partial frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            div_q   <= 8'd0;
            phase_q <= 1'b0;
            bit_q   <= '0;
            quiet_q <= 16'd0;
            shift_q <= '0;
            csn_q   <= 1'b1;
            sck_q   <= 1'b1;
            busy_q  <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            phase_q <= phase_d;
            bit_q   <= bit_d;
            quiet_q <= quiet_d;
            shift_q <= shift_d;
            csn_q   <= csn_d;
            sck_q   <= sck_d;
            busy_q  <= busy_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

`ifdef ADC1_AVG_EN
    // Averaging accumulator; a rising auto_en starts a fresh average.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q     <= '0;
            avg_cnt_q <= '0;
            auto_en_q <= 1'b0;
        end else begin
            auto_en_q <= auto_en;
            if (avg_clr_s) begin
                acc_q     <= '0;
                avg_cnt_q <= '0;
            end else begin
                acc_q     <= acc_d;
                avg_cnt_q <= avg_cnt_d;
            end
        end
    end
`endif

    assign adc_csn      = csn_q;
    assign adc_sck      = sck_q;
    assign busy         = busy_q;
    assign sample_data  = data_q;
    assign sample_valid = valid_q;
    assign frame_err    = err_q;

endmodule

// File: tb/tb_adc1_spi_reader.sv
// -----------------------------------------------------------------------------
// tb_adc1_spi_reader
// Scoreboard bench: stimulus pushes the expected sample into a queue, a
// monitor pops and compares on every sample_valid. A behavioural ADC drives
// each frame word MSB first after every SCK falling edge.
// -----------------------------------------------------------------------------
module tb_adc1_spi_reader;

    localparam int LATENCY = 1 + 4 + 2 * 4 * 16;

    typedef struct {
        logic [11:0] data;
        logic        err;
        int          lat;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        auto_en;
    logic        adc_csn;
    logic        adc_sck;
    logic        adc_sdo;
    logic [11:0] sample_data;
    logic        sample_valid;
    logic        frame_err;
    logic        err_clr;
    logic        busy;

    int          checks;
    int          errors;
    int          cyc;
    int          start_cyc;
    int          valid_count;
    int          frames_started;
    int          falls;
    int          last_falls;
    int          last_rise;
    int          min_gap;
    int          bit_idx;
    bit          gap_track;
    logic        err_model;
    logic [15:0] cur;
    logic [15:0] adc_q[$];
    exp_t        exp_q[$];

    adc1_spi_reader dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .auto_en      (auto_en),
        .adc_csn      (adc_csn),
        .adc_sck      (adc_sck),
        .adc_sdo      (adc_sdo),
        .sample_data  (sample_data),
        .sample_valid (sample_valid),
        .frame_err    (frame_err),
        .err_clr      (err_clr),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Behavioural ADC: new frame word on CSN fall, next bit after each SCK fall.
    always @(negedge adc_csn) begin
        if (adc_q.size() > 0) cur = adc_q.pop_front();
        else cur = 16'($urandom);
        bit_idx = 0;
        falls   = 0;
        frames_started++;
        if (gap_track && (cyc - last_rise) < min_gap) min_gap = cyc - last_rise;
    end

    always @(negedge adc_sck) begin
        if (adc_csn === 1'b0) begin
            if (bit_idx < 16) adc_sdo = cur[15 - bit_idx];
            bit_idx++;
            falls++;
        end
    end

    always @(posedge adc_csn) begin
        last_falls = falls;
        last_rise  = cyc;
    end

    // Monitor: every valid strobe must match the oldest expectation.
    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (sample_valid === 1'b1) begin
            valid_count++;
            if (exp_q.size() == 0) begin
                chk("unexpected_valid", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("sample_data", 32'(sample_data), 32'(e.data));
                chk("frame_err_at_valid", 32'(frame_err), 32'(e.err));
                if (e.lat >= 0) chk("latency", 32'(cyc - start_cyc), 32'(e.lat));
            end
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (busy === 1'b0) break;
        end
        chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic wait_frames(input int n);
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (frames_started >= n) break;
        end
        chk("frame_start_timeout", 32'(frames_started >= n), 32'd1);
    endtask

    task automatic push_exp(input logic [15:0] w, input bit chk_lat);
        exp_t e;
        err_model = err_model | (w[15:12] != 4'd0);
        e.data    = w[11:0];
        e.err     = err_model;
        e.lat     = chk_lat ? LATENCY : -1;
        exp_q.push_back(e);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start     = 1'b1;
        start_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic do_shot(input logic [15:0] w, input bit expect_out);
        adc_q.push_back(w);
        if (expect_out) push_exp(w, 1'b1);
        pulse_start();
        wait_idle();
    endtask

    task automatic clear_err();
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr   = 1'b0;
        err_model = 1'b0;
        chk("err_clr", 32'(frame_err), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_f;
        int base_v;
        logic [15:0] w;
        rst_n = 1'b0; start = 1'b0; auto_en = 1'b0; err_clr = 1'b0; adc_sdo = 1'b0;
        checks = 0; errors = 0; cyc = 0; valid_count = 0; frames_started = 0;
        last_rise = 0; min_gap = 1000000; gap_track = 1'b0; err_model = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_csn", 32'(adc_csn), 32'd1);
        chk("rst_sck", 32'(adc_sck), 32'd1);
        chk("rst_data", 32'(sample_data), 32'd0);
        chk("rst_valid", 32'(sample_valid), 32'd0);
        chk("rst_err", 32'(frame_err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

`ifdef ADC1_AVG_EN
        // Eight single shots averaged into one output.
        begin
            int sum;
            sum    = 0;
            base_v = valid_count;
            for (int i = 0; i < 8; i++) begin
                w = 16'h0100 + 16'(i);
                sum += int'(w);
                if (i == 7) begin
                    exp_t e;
                    e.data = 12'(sum / 8);
                    e.err  = 1'b0;
                    e.lat  = LATENCY;
                    exp_q.push_back(e);
                end
                do_shot(w, 1'b0);
            end
            repeat (20) @(negedge clk);
            chk("avg_valid_count", 32'(valid_count - base_v), 32'd1);
            chk("avg_data_0x103", 32'(sample_data), 32'h103);
        end
`else
        // Single shot at defaults.
        do_shot(16'h0ABC, 1'b1);
        chk("sck_falls", 32'(last_falls), 32'd16);
        chk("err_after_abc", 32'(frame_err), 32'd0);

        // Random frames, roughly half with a nonzero leading nibble.
        for (int i = 0; i < 4; i++) begin
            w = 16'($urandom);
            if ($urandom_range(0, 1) == 0) w[15:12] = 4'd0;
            do_shot(w, 1'b1);
            chk("rand_err", 32'(frame_err), 32'(err_model));
        end
        clear_err();

        // Leading-bit error is sticky and cleared by err_clr.
        do_shot(16'h8123, 1'b1);
        repeat (10) @(negedge clk);
        chk("err_sticky", 32'(frame_err), 32'd1);
        clear_err();

        // New error coinciding with err_clr: the set wins.
        adc_q.push_back(16'hF456);
        push_exp(16'hF456, 1'b1);
        pulse_start();
        repeat (131) @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        wait_idle();
        chk("err_set_wins", 32'(frame_err), 32'd1);
        clear_err();

        // Auto mode: three frames, then auto_en dropped during frame 3.
        base_f = frames_started;
        adc_q.push_back(16'h0111); push_exp(16'h0111, 1'b0);
        adc_q.push_back(16'h0222); push_exp(16'h0222, 1'b0);
        adc_q.push_back(16'h0333); push_exp(16'h0333, 1'b0);
        gap_track = 1'b1;
        @(negedge clk);
        auto_en = 1'b1;
        wait_frames(base_f + 3);
        repeat (50) @(negedge clk);
        auto_en = 1'b0;
        wait_idle();
        repeat (60) @(negedge clk);
        gap_track = 1'b0;
        chk("auto_frames", 32'(frames_started - base_f), 32'd3);
        chk("auto_all_seen", 32'(exp_q.size()), 32'd0);
        chk("auto_csn_gap", 32'(min_gap >= 20), 32'd1);
        chk("auto_idle_csn", 32'(adc_csn), 32'd1);

        // Starts while busy are dropped.
        base_f = frames_started;
        base_v = valid_count;
        adc_q.push_back(16'h0777);
        push_exp(16'h0777, 1'b1);
        pulse_start();
        repeat (30) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (60) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        repeat (40) @(negedge clk);
        chk("busy_start_valids", 32'(valid_count - base_v), 32'd1);
        chk("busy_start_frames", 32'(frames_started - base_f), 32'd1);

        // Reset during SHIFT bit 7: immediate idle pins, no sample.
        base_v = valid_count;
        adc_q.push_back(16'h0FFF);
        pulse_start();
        repeat (62) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_csn", 32'(adc_csn), 32'd1);
        chk("mid_rst_sck", 32'(adc_sck), 32'd1);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_valid", 32'(sample_valid), 32'd0);
        chk("mid_rst_data", 32'(sample_data), 32'd0);
        err_model = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (200) @(negedge clk);
        chk("mid_rst_no_valid", 32'(valid_count - base_v), 32'd0);
        do_shot(16'h0A5A, 1'b1);
        chk("post_rst_falls", 32'(last_falls), 32'd16);
`endif

        repeat (10) @(negedge clk);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
